// File: rtl/fft_pkg.sv
// Shared constants, FSM encodings and index/bank mapping helpers for the FFT RAM sequencer.
package fft_pkg;

    localparam int unsigned STAGES_DEF = 6;
    localparam int unsigned BF_LAT_DEF = 4;
    localparam int unsigned MAX_STAGES = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Per-bank address width: N/4 words per bank with N = 4^stages.
    function automatic int unsigned a_bit_of(input int unsigned stages);
        return 2 * stages - 2;
    endfunction

    // Stage counter width, at least one bit.
    function automatic int unsigned stage_bits(input int unsigned stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    // Point index of leg k: butterfly number with base-4 digit k inserted at digit position pos.
    function automatic logic [31:0] insert_digit(input logic [31:0] b, input int unsigned pos,
                                                 input logic [1:0] k);
        logic [31:0] low_mask;
        low_mask = (32'd1 << (2 * pos)) - 32'd1;
        return ((b & ~low_mask) << 2) | (32'(k) << (2 * pos)) | (b & low_mask);
    endfunction

    // Bank of a point: sum of its base-4 digits modulo 4.
    function automatic logic [1:0] bank_of(input logic [31:0] idx, input int unsigned stages);
        logic [1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < MAX_STAGES; i++) begin
            if (i < stages) begin
                acc = acc + idx[2*i +: 2];
            end
        end
        return acc;
    endfunction

    // Word address of a point within its bank.
    function automatic logic [31:0] addr_of(input logic [31:0] idx);
        return idx >> 2;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Enabled shift register carrying read valid/address/select forward to the write side.
module fft_addr_delay #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    // Shift one position per enabled cycle; a stall freezes the whole line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else if (en) begin
            pipe[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_ram_seq.sv
// Address/enable sequencer for the 4-bank in-place radix-4 FFT RAM.
module fft_ram_seq
    import fft_pkg::*;
#(
    parameter int unsigned STAGES = STAGES_DEF,
    parameter int unsigned BF_LAT = BF_LAT_DEF
) (
    input  logic                            iCLK,
    input  logic                            iRST_N,
    input  logic                            iSTART,
    input  logic                            iEN,
    output logic                            oBUSY,
    output logic                            oDONE,
    output logic [stage_bits(STAGES)-1:0]   oSTAGE,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_RD_0,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_RD_1,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_RD_2,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_RD_3,
    output logic [1:0]                      oRD_SEL_0,
    output logic [1:0]                      oRD_SEL_1,
    output logic [1:0]                      oRD_SEL_2,
    output logic [1:0]                      oRD_SEL_3,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_WR_0,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_WR_1,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_WR_2,
    output logic [a_bit_of(STAGES)-1:0]     oADDR_WR_3,
    output logic [1:0]                      oWR_SEL_0,
    output logic [1:0]                      oWR_SEL_1,
    output logic [1:0]                      oWR_SEL_2,
    output logic [1:0]                      oWR_SEL_3,
    output logic                            oWE_0,
    output logic                            oWE_1,
    output logic                            oWE_2,
    output logic                            oWE_3
);

    localparam int unsigned A_BIT = a_bit_of(STAGES);
    localparam int unsigned S_BIT = stage_bits(STAGES);
    localparam int unsigned D_BIT = $clog2(BF_LAT);
    localparam int unsigned PW    = 1 + 4 * A_BIT + 8;

    localparam logic [A_BIT-1:0] B_LAST = '1;
    localparam logic [S_BIT-1:0] S_LAST = S_BIT'(STAGES - 1);
    localparam logic [D_BIT-1:0] D_LAST = D_BIT'(BF_LAT - 1);

    logic [1:0]       state, state_n;
    logic [S_BIT-1:0] stg, stg_n;
    logic [A_BIT-1:0] bfly, bfly_n;
    logic [D_BIT-1:0] drain, drain_n;

    logic [31:0]      leg_idx  [4];
    logic [1:0]       leg_bank [4];
    logic [A_BIT-1:0] leg_addr [4];
    logic [A_BIT-1:0] addr_c   [4];
    logic [1:0]       sel_c    [4];
    int unsigned      pos_c;

    logic [A_BIT-1:0] rd_addr [4];
    logic [1:0]       rd_sel  [4];
    logic             rd_valid;
    logic             busy_q;
    logic             done_q;

    logic [PW-1:0]    dl_in;
    logic [PW-1:0]    dl_out;
    logic [A_BIT-1:0] wr_addr [4];
    logic [1:0]       wr_sel  [4];
    logic             wr_valid;

    // FSM and counter state register; iEN low holds everything.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
            stg   <= '0;
            bfly  <= '0;
            drain <= '0;
        end else if (iEN) begin
            state <= state_n;
            stg   <= stg_n;
            bfly  <= bfly_n;
            drain <= drain_n;
        end
    end

    // Next-state: one butterfly per RUN cycle, BF_LAT drain cycles closing each stage.
    always_comb begin
        state_n = state;
        stg_n   = stg;
        bfly_n  = bfly;
        drain_n = drain;
        case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    state_n = ST_RUN;
                    stg_n   = '0;
                    bfly_n  = '0;
                end
            end
            ST_RUN: begin
                if (bfly == B_LAST) begin
                    state_n = ST_DRAIN;
                    bfly_n  = '0;
                    drain_n = '0;
                end else begin
                    bfly_n = bfly + A_BIT'(1);
                end
            end
            ST_DRAIN: begin
                if (drain == D_LAST) begin
                    bfly_n = '0;
                    if (stg == S_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                        stg_n   = stg + S_BIT'(1);
                    end
                end else begin
                    drain_n = drain + D_BIT'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                stg_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Leg index/bank/address for the butterfly about to be issued, routed to banks.
    always_comb begin
        pos_c = 32'(STAGES - 1) - 32'(stg_n);
        for (int j = 0; j < 4; j++) begin
            addr_c[j] = '0;
            sel_c[j]  = '0;
        end
        for (int k = 0; k < 4; k++) begin
            leg_idx[k]  = insert_digit(32'(bfly_n), pos_c, 2'(k));
            leg_bank[k] = bank_of(leg_idx[k], STAGES);
            leg_addr[k] = A_BIT'(addr_of(leg_idx[k]));
        end
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (leg_bank[k] == 2'(j)) begin
                    addr_c[j] = leg_addr[k];
                    sel_c[j]  = 2'(k);
                end
            end
        end
    end

    // Registered read side and status; read address/select hold outside RUN.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int j = 0; j < 4; j++) begin
                rd_addr[j] <= '0;
                rd_sel[j]  <= '0;
            end
            rd_valid <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (iEN) begin
            if (state_n == ST_RUN) begin
                for (int j = 0; j < 4; j++) begin
                    rd_addr[j] <= addr_c[j];
                    rd_sel[j]  <= sel_c[j];
                end
            end
            rd_valid <= (state_n == ST_RUN);
            busy_q   <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
            done_q   <= (state_n == ST_DONE);
        end
    end

    // Pack read side for the write-side delay line.
    always_comb begin
        dl_in = '0;
        for (int j = 0; j < 4; j++) begin
            dl_in[2*j +: 2]           = rd_sel[j];
            dl_in[8 + j*A_BIT +: A_BIT] = rd_addr[j];
        end
        dl_in[PW-1] = rd_valid;
    end

    fft_addr_delay #(
        .W     (PW),
        .DEPTH (BF_LAT)
    ) u_delay (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .en    (iEN),
        .d     (dl_in),
        .q     (dl_out)
    );

    // Unpack delayed write side.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            wr_sel[j]  = dl_out[2*j +: 2];
            wr_addr[j] = dl_out[8 + j*A_BIT +: A_BIT];
        end
        wr_valid = dl_out[PW-1];
    end

    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oSTAGE     = stg;
    assign oADDR_RD_0 = rd_addr[0];
    assign oADDR_RD_1 = rd_addr[1];
    assign oADDR_RD_2 = rd_addr[2];
    assign oADDR_RD_3 = rd_addr[3];
    assign oRD_SEL_0  = rd_sel[0];
    assign oRD_SEL_1  = rd_sel[1];
    assign oRD_SEL_2  = rd_sel[2];
    assign oRD_SEL_3  = rd_sel[3];
    assign oADDR_WR_0 = wr_addr[0];
    assign oADDR_WR_1 = wr_addr[1];
    assign oADDR_WR_2 = wr_addr[2];
    assign oADDR_WR_3 = wr_addr[3];
    assign oWR_SEL_0  = wr_sel[0];
    assign oWR_SEL_1  = wr_sel[1];
    assign oWR_SEL_2  = wr_sel[2];
    assign oWR_SEL_3  = wr_sel[3];
    // A stalled cycle never writes.
    assign oWE_0      = wr_valid & iEN;
    assign oWE_1      = wr_valid & iEN;
    assign oWE_2      = wr_valid & iEN;
    assign oWE_3      = wr_valid & iEN;

endmodule

// File: tb/tb_fft_ram_seq.sv
// Directed bench for fft_ram_seq (STAGES=2, BF_LAT=3) plus a randomly stalled STAGES=3 run.
module tb_fft_ram_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, en, start3, en3;

    // STAGES=2 instance
    logic       busy, done;
    logic [0:0] stage;
    logic [1:0] ra0, ra1, ra2, ra3, rs0, rs1, rs2, rs3;
    logic [1:0] wa0, wa1, wa2, wa3, ws0, ws1, ws2, ws3;
    logic       we0, we1, we2, we3;

    // STAGES=3 instance
    logic       busy3, done3;
    logic [1:0] stage3;
    logic [3:0] ra30, ra31, ra32, ra33, wa30, wa31, wa32, wa33;
    logic [1:0] rs30, rs31, rs32, rs33, ws30, ws31, ws32, ws33;
    logic       we30, we31, we32, we33;

    fft_ram_seq #(.STAGES(2), .BF_LAT(3)) u_dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iEN(en),
        .oBUSY(busy), .oDONE(done), .oSTAGE(stage),
        .oADDR_RD_0(ra0), .oADDR_RD_1(ra1), .oADDR_RD_2(ra2), .oADDR_RD_3(ra3),
        .oRD_SEL_0(rs0), .oRD_SEL_1(rs1), .oRD_SEL_2(rs2), .oRD_SEL_3(rs3),
        .oADDR_WR_0(wa0), .oADDR_WR_1(wa1), .oADDR_WR_2(wa2), .oADDR_WR_3(wa3),
        .oWR_SEL_0(ws0), .oWR_SEL_1(ws1), .oWR_SEL_2(ws2), .oWR_SEL_3(ws3),
        .oWE_0(we0), .oWE_1(we1), .oWE_2(we2), .oWE_3(we3)
    );

    fft_ram_seq #(.STAGES(3), .BF_LAT(4)) u_dut3 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start3), .iEN(en3),
        .oBUSY(busy3), .oDONE(done3), .oSTAGE(stage3),
        .oADDR_RD_0(ra30), .oADDR_RD_1(ra31), .oADDR_RD_2(ra32), .oADDR_RD_3(ra33),
        .oRD_SEL_0(rs30), .oRD_SEL_1(rs31), .oRD_SEL_2(rs32), .oRD_SEL_3(rs33),
        .oADDR_WR_0(wa30), .oADDR_WR_1(wa31), .oADDR_WR_2(wa32), .oADDR_WR_3(wa33),
        .oWR_SEL_0(ws30), .oWR_SEL_1(ws31), .oWR_SEL_2(ws32), .oWR_SEL_3(ws33),
        .oWE_0(we30), .oWE_1(we31), .oWE_2(we32), .oWE_3(we33)
    );

    logic [7:0] rd_a, rd_s, wr_a, wr_s;
    logic [3:0] we_v, we3_v;
    assign rd_a  = {ra3, ra2, ra1, ra0};
    assign rd_s  = {rs3, rs2, rs1, rs0};
    assign wr_a  = {wa3, wa2, wa1, wa0};
    assign wr_s  = {ws3, ws2, ws1, ws0};
    assign we_v  = {we3, we2, we1, we0};
    assign we3_v = {we33, we32, we31, we30};

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Four 2-bit per-bank values packed bank3..bank0.
    function automatic logic [31:0] p4(input int b0, input int b1, input int b2, input int b3);
        return {24'd0, 2'(b3), 2'(b2), 2'(b1), 2'(b0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full uninterrupted transform with start pulses while busy and coincident with DONE.
    task automatic run_plain(input string tag);
        start = 1'b1; en = 1'b1;
        step();
        for (int c = 1; c <= 17; c++) begin
            start = (c == 5) || (c == 15);
            #1;
            chk({tag, "_we"},   32'(we_v), ((c >= 4 && c <= 7) || (c >= 11 && c <= 14)) ? 32'hF : 32'h0);
            chk({tag, "_busy"}, 32'(busy), (c >= 1 && c <= 14) ? 32'd1 : 32'd0);
            chk({tag, "_done"}, 32'(done), (c == 15) ? 32'd1 : 32'd0);
            if (c == 1) begin
                chk({tag, "_c1_rda"}, 32'(rd_a), p4(0, 1, 2, 3));
                chk({tag, "_c1_rds"}, 32'(rd_s), p4(0, 1, 2, 3));
            end
            if (c == 3) begin
                chk({tag, "_c3_rda"}, 32'(rd_a), p4(2, 3, 0, 1));
                chk({tag, "_c3_rds"}, 32'(rd_s), p4(2, 3, 0, 1));
                chk({tag, "_c3_stg"}, 32'(stage), 32'd0);
            end
            if (c == 4) begin
                chk({tag, "_c4_wra"}, 32'(wr_a), p4(0, 1, 2, 3));
                chk({tag, "_c4_wrs"}, 32'(wr_s), p4(0, 1, 2, 3));
            end
            if (c == 8) begin
                chk({tag, "_c8_rda"}, 32'(rd_a), p4(0, 0, 0, 0));
                chk({tag, "_c8_rds"}, 32'(rd_s), p4(0, 1, 2, 3));
                chk({tag, "_c8_stg"}, 32'(stage), 32'd1);
            end
            if (c == 9) begin
                chk({tag, "_c9_rda"}, 32'(rd_a), p4(1, 1, 1, 1));
                chk({tag, "_c9_rds"}, 32'(rd_s), p4(3, 0, 1, 2));
            end
            if (c == 14) begin
                chk({tag, "_c14_wra"}, 32'(wr_a), p4(3, 3, 3, 3));
                chk({tag, "_c14_wrs"}, 32'(wr_s), p4(1, 2, 3, 0));
            end
            step();
        end
        start = 1'b0;
    endtask

    logic [15:0] seen [4];
    int          dups, touched, wcount, mask, got_done, bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; en = 1'b1; start3 = 1'b0; en3 = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_rda", 32'(rd_a), 32'd0);
        chk("rst_rds", 32'(rd_s), 32'd0);
        chk("rst_wra", 32'(wr_a), 32'd0);
        chk("rst_wrs", 32'(wr_s), 32'd0);
        chk("rst_we", 32'(we_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Plain run
        run_plain("run");

        // Stall for cycles 2..3
        start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            en = !(c == 2 || c == 3);
            #1;
            chk("stall_we",   32'(we_v), ((c >= 6 && c <= 9) || (c >= 13 && c <= 16)) ? 32'hF : 32'h0);
            chk("stall_busy", 32'(busy), (c >= 1 && c <= 16) ? 32'd1 : 32'd0);
            chk("stall_done", 32'(done), (c == 17) ? 32'd1 : 32'd0);
            if (c == 1) chk("stall_c1_rda", 32'(rd_a), p4(0, 1, 2, 3));
            if (c >= 2 && c <= 4) begin
                chk("stall_b1_rda", 32'(rd_a), p4(3, 0, 1, 2));
                chk("stall_b1_rds", 32'(rd_s), p4(3, 0, 1, 2));
            end
            if (c == 6) chk("stall_c6_wra", 32'(wr_a), p4(0, 1, 2, 3));
            step();
        end
        en = 1'b1;

        // Reset in the middle of a transform
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(we_v), 32'd0);
        chk("abort_rda", 32'(rd_a), 32'd0);
        chk("abort_wra", 32'(wr_a), 32'd0);
        chk("abort_stage", 32'(stage), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done || busy || (we_v != 4'h0)) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        run_plain("rerun");

        // STAGES=3 run with random stalls
        for (int j = 0; j < 4; j++) seen[j] = '0;
        dups = 0; touched = 0; wcount = 0; got_done = 0;
        start3 = 1'b1; en3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            en3 = ($urandom_range(0, 3) != 0);
            #1;
            if (!en3) begin
                chk("r3_we_stall", 32'(we3_v), 32'h0);
            end else if (we3_v != 4'h0) begin
                chk("r3_we_all", 32'(we3_v), 32'hF);
                mask = (1 << ws30) | (1 << ws31) | (1 << ws32) | (1 << ws33);
                chk("r3_sel_distinct", 32'(mask), 32'hF);
                if (seen[0][wa30]) dups++; else touched++;
                if (seen[1][wa31]) dups++; else touched++;
                if (seen[2][wa32]) dups++; else touched++;
                if (seen[3][wa33]) dups++; else touched++;
                seen[0][wa30] = 1'b1; seen[1][wa31] = 1'b1;
                seen[2][wa32] = 1'b1; seen[3][wa33] = 1'b1;
                wcount++;
                if (wcount % 16 == 0) begin
                    chk("r3_stage_dups", 32'(dups), 32'd0);
                    chk("r3_stage_cover", 32'(touched), 32'd64);
                    for (int j = 0; j < 4; j++) seen[j] = '0;
                    dups = 0; touched = 0;
                end
            end
            if (done3) begin
                got_done = 1;
                break;
            end
            step();
        end
        chk("r3_done_seen", 32'(got_done), 32'd1);
        chk("r3_writes", 32'(wcount), 32'd48);
        chk("r3_busy_at_done", 32'(busy3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
